// File: rtl/mips_multicycle_core.sv
// ----------------------------------------------------------------------------
// mips_multicycle_core
//
// Multi-cycle MIPS-subset core: datapath, 32 x 32 register file and FSM
// controller, attached to one unified instruction/data memory through a
// request/ready handshake. Every instruction is fetched and executed over
// several states; the memory may stretch FETCH and MEM by holding ready low.
//
// Ports
//   i_clk          rising-edge clock
//   i_rst          synchronous active-low reset
//   o_mem_req      memory request valid
//   o_mem_we       1 = write (sw), 0 = read
//   o_mem_addr     word-aligned byte address (low ADDR_W bits)
//   o_mem_wdata    store data
//   i_mem_rdata    read data, valid while i_mem_ready = 1
//   i_mem_ready    completes the current request
//   o_pc           architectural PC
//   o_retire       one-cycle pulse when an instruction completes
//   o_illegal      sticky flag for an unsupported opcode/funct
// ----------------------------------------------------------------------------
module mips_multicycle_core #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          ADDR_W   = 32
) (
    input  logic              i_clk,
    input  logic              i_rst,
    output logic              o_mem_req,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [31:0]       o_mem_wdata,
    input  logic [31:0]       i_mem_rdata,
    input  logic              i_mem_ready,
    output logic [31:0]       o_pc,
    output logic              o_retire,
    output logic              o_illegal
);

    // state  | meaning
    // FETCH  | read instruction at PC, wait for ready, latch IR and PC+4
    // DECODE | read rs/rt into A/B, check legality
    // EXEC   | ALU operation; branches and jumps resolve and retire here
    // MEM    | load/store access at A+sext(imm); sw retires on ready
    // WB     | register write, PC update, retire
    // HALT   | illegal instruction seen; idle until reset
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    state_t      r_state;
    state_t      w_state_next;

    logic [31:0] r_pc;
    logic [31:0] r_pcp4;
    logic [31:0] r_ir;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [31:0] r_alu;
    logic [31:0] r_mdr;
    logic        r_illegal;
    // Low during reset and for the first cycle after it, so the first
    // request rises only one cycle after reset is released.
    logic        r_run;
    logic [31:0] r_rf [32];

    // ------------------------------------------------------------------
    // Instruction fields and decode
    // ------------------------------------------------------------------
    logic [5:0]  w_op;
    logic [4:0]  w_rs;
    logic [4:0]  w_rt;
    logic [4:0]  w_rd;
    logic [5:0]  w_funct;
    logic [31:0] w_imm_sext;
    logic [31:0] w_br_target;
    logic [31:0] w_j_target;
    logic        w_unused_shamt;

    assign w_op           = r_ir[31:26];
    assign w_rs           = r_ir[25:21];
    assign w_rt           = r_ir[20:16];
    assign w_rd           = r_ir[15:11];
    assign w_funct        = r_ir[5:0];
    assign w_unused_shamt = ^r_ir[10:6];
    assign w_imm_sext     = {{16{r_ir[15]}}, r_ir[15:0]};
    assign w_br_target    = r_pcp4 + {w_imm_sext[29:0], 2'b00};
    assign w_j_target     = {r_pcp4[31:28], r_ir[25:0], 2'b00};

    logic w_is_rtype;
    logic w_is_add;
    logic w_is_sub;
    logic w_is_and;
    logic w_is_or;
    logic w_is_slt;
    logic w_is_jr;
    logic w_is_addi;
    logic w_is_slti;
    logic w_is_lw;
    logic w_is_sw;
    logic w_is_beq;
    logic w_is_j;
    logic w_is_jal;
    logic w_legal;

    assign w_is_rtype = (w_op == OP_RTYPE);
    assign w_is_add   = w_is_rtype && (w_funct == FN_ADD);
    assign w_is_sub   = w_is_rtype && (w_funct == FN_SUB);
    assign w_is_and   = w_is_rtype && (w_funct == FN_AND);
    assign w_is_or    = w_is_rtype && (w_funct == FN_OR);
    assign w_is_slt   = w_is_rtype && (w_funct == FN_SLT);
    assign w_is_jr    = w_is_rtype && (w_funct == FN_JR);
    assign w_is_addi  = (w_op == OP_ADDI);
    assign w_is_slti  = (w_op == OP_SLTI);
    assign w_is_lw    = (w_op == OP_LW);
    assign w_is_sw    = (w_op == OP_SW);
    assign w_is_beq   = (w_op == OP_BEQ);
    assign w_is_j     = (w_op == OP_J);
    assign w_is_jal   = (w_op == OP_JAL);

    assign w_legal = w_is_add | w_is_sub | w_is_and | w_is_or | w_is_slt |
                     w_is_jr  | w_is_addi | w_is_slti | w_is_lw | w_is_sw |
                     w_is_beq | w_is_j   | w_is_jal;

    // ------------------------------------------------------------------
    // ALU: R-type uses B, everything else uses the sign-extended immediate
    // ------------------------------------------------------------------
    logic [31:0] w_alu_b;
    logic [31:0] w_alu_y;

    assign w_alu_b = w_is_rtype ? r_b : w_imm_sext;

    always_comb begin
        w_alu_y = r_a + w_alu_b;
        if (w_is_sub) begin
            w_alu_y = r_a - w_alu_b;
        end else if (w_is_and) begin
            w_alu_y = r_a & w_alu_b;
        end else if (w_is_or) begin
            w_alu_y = r_a | w_alu_b;
        end else if (w_is_slt || w_is_slti) begin
            w_alu_y = {31'd0, ($signed(r_a) < $signed(w_alu_b))};
        end
    end

    // ------------------------------------------------------------------
    // Write-back selection
    // ------------------------------------------------------------------
    logic [4:0]  w_wb_dst;
    logic [31:0] w_wb_data;

    always_comb begin
        w_wb_dst  = w_rt;
        w_wb_data = r_alu;
        if (w_is_jal) begin
            w_wb_dst  = 5'd31;
            w_wb_data = r_pcp4;
        end else if (w_is_rtype) begin
            w_wb_dst  = w_rd;
        end else if (w_is_lw) begin
            w_wb_data = r_mdr;
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_FETCH: begin
                if (r_run && i_mem_ready) begin
                    w_state_next = S_DECODE;
                end
            end
            S_DECODE: begin
                w_state_next = w_legal ? S_EXEC : S_HALT;
            end
            S_EXEC: begin
                if (w_is_lw || w_is_sw) begin
                    w_state_next = S_MEM;
                end else if (w_is_beq || w_is_j || w_is_jr) begin
                    w_state_next = S_FETCH;
                end else begin
                    w_state_next = S_WB;
                end
            end
            S_MEM: begin
                if (i_mem_ready) begin
                    w_state_next = w_is_sw ? S_FETCH : S_WB;
                end
            end
            S_WB:    w_state_next = S_FETCH;
            S_HALT:  w_state_next = S_HALT;
            default: w_state_next = S_HALT;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    logic [31:0] w_addr_full;

    always_comb begin
        o_mem_req   = 1'b0;
        o_mem_we    = 1'b0;
        o_retire    = 1'b0;
        w_addr_full = {r_pc[31:2], 2'b00};
        case (r_state)
            S_FETCH: begin
                o_mem_req = r_run;
            end
            S_EXEC: begin
                o_retire = w_is_beq | w_is_j | w_is_jr;
            end
            S_MEM: begin
                o_mem_req   = 1'b1;
                o_mem_we    = w_is_sw;
                o_retire    = w_is_sw & i_mem_ready;
                w_addr_full = {r_alu[31:2], 2'b00};
            end
            S_WB: begin
                o_retire = 1'b1;
            end
            default: begin
                o_mem_req = 1'b0;
            end
        endcase
    end

    assign o_mem_addr  = w_addr_full[ADDR_W-1:0];
    assign o_mem_wdata = r_b;
    assign o_pc        = r_pc;
    assign o_illegal   = r_illegal;

    // ------------------------------------------------------------------
    // Datapath registers and register file
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_pc      <= RESET_PC;
            r_pcp4    <= '0;
            r_ir      <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_alu     <= '0;
            r_mdr     <= '0;
            r_illegal <= 1'b0;
            r_run     <= 1'b0;
            for (int i = 0; i < 32; i++) begin
                r_rf[i] <= '0;
            end
        end else begin
            r_run <= 1'b1;
            case (r_state)
                S_FETCH: begin
                    if (r_run && i_mem_ready) begin
                        r_ir   <= i_mem_rdata;
                        r_pcp4 <= r_pc + 32'd4;
                    end
                end
                S_DECODE: begin
                    r_a <= r_rf[w_rs];
                    r_b <= r_rf[w_rt];
                    if (!w_legal) begin
                        r_illegal <= 1'b1;
                    end
                end
                S_EXEC: begin
                    r_alu <= w_alu_y;
                    if (w_is_beq) begin
                        r_pc <= (r_a == r_b) ? w_br_target : r_pcp4;
                    end else if (w_is_j) begin
                        r_pc <= w_j_target;
                    end else if (w_is_jr) begin
                        r_pc <= {r_a[31:2], 2'b00};
                    end
                end
                S_MEM: begin
                    if (i_mem_ready) begin
                        if (w_is_sw) begin
                            r_pc <= r_pcp4;
                        end else begin
                            r_mdr <= i_mem_rdata;
                        end
                    end
                end
                S_WB: begin
                    // $0 is never written, so reads of it stay zero.
                    if (w_wb_dst != 5'd0) begin
                        r_rf[w_wb_dst] <= w_wb_data;
                    end
                    r_pc <= w_is_jal ? w_j_target : r_pcp4;
                end
                default: begin
                    r_run <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mips_multicycle_core.sv
module tb_mips_multicycle_core;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic [31:0] pc;
    logic        retire;
    logic        illegal;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [0:255];
    int          lat = 0;
    int          wcnt = 0;
    bit          hold_store = 1'b0;
    bit          spur = 1'b0;

    mips_multicycle_core #(
        .RESET_PC (32'h0000_0000),
        .ADDR_W   (32)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .o_mem_req   (mem_req),
        .o_mem_we    (mem_we),
        .o_mem_addr  (mem_addr),
        .o_mem_wdata (mem_wdata),
        .i_mem_rdata (mem_rdata),
        .i_mem_ready (mem_ready),
        .o_pc        (pc),
        .o_retire    (retire),
        .o_illegal   (illegal)
    );

    always #5 clk = ~clk;

    // Memory model: ready after `lat` wait cycles; spur forces ready high
    // regardless of req; hold_store stalls writes indefinitely.
    assign mem_ready = spur | (mem_req && (wcnt >= lat) && !(hold_store && mem_we));
    assign mem_rdata = mem[mem_addr[9:2]];

    always @(posedge clk) begin
        if (mem_req && mem_ready) begin
            if (mem_we) mem[mem_addr[9:2]] = mem_wdata;
            wcnt <= 0;
        end else if (mem_req) begin
            wcnt <= wcnt + 1;
        end else begin
            wcnt <= 0;
        end
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;
    endtask

    // Returns cycles until retire is seen; max+1 on timeout.
    task automatic wait_retire(input int max, output int cycles);
        cycles = 0;
        forever begin
            step();
            cycles++;
            if (retire === 1'b1) break;
            if (cycles > max) break;
        end
    endtask

    task automatic test_reset();
        int c;
        clear_mem();
        mem[0] = 32'h2001_0005;
        lat = 0;
        spur = 1'b1;
        rst = 1'b0;
        step();
        step();
        checks++; if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h want 00000000", pc); end
        checks++; if (retire !== 1'b0) begin errors++; $display("FAIL reset_retire: got %b want 0", retire); end
        checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL reset_illegal: got %b want 0", illegal); end
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", mem_req); end
        spur = 1'b0;
        rst = 1'b1;
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL req_release_cycle: got %b want 0", mem_req); end
        step();
        checks++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h0)
            begin errors++; $display("FAIL first_fetch: req=%b we=%b addr=%h want 1 0 00000000", mem_req, mem_we, mem_addr); end
        c = 0;
    endtask

    task automatic test_alu_basic();
        int c;
        int total;
        clear_mem();
        mem[0] = 32'h2001_0005;   // addi $1,$0,5
        mem[1] = 32'h2002_FFFD;   // addi $2,$0,-3
        mem[2] = 32'h0022_1820;   // add  $3,$1,$2
        mem[3] = 32'h0041_202A;   // slt  $4,$2,$1
        lat = 0;
        do_reset();
        total = 0;
        for (int i = 0; i < 4; i++) begin
            wait_retire(20, c);
            total += c;
            checks++; if (total !== 4 * (i + 1))
                begin errors++; $display("FAIL retire_cycle_%0d: got %0d want %0d", i, total, 4 * (i + 1)); end
        end
        checks++; if (pc !== 32'h0C) begin errors++; $display("FAIL pc_in_retire: got %h want 0000000c", pc); end
        step();
        checks++; if (pc !== 32'h10) begin errors++; $display("FAIL pc_after_retire: got %h want 00000010", pc); end
        checks++; if (dut.r_rf[1] !== 32'd5) begin errors++; $display("FAIL reg1: got %h want 00000005", dut.r_rf[1]); end
        checks++; if (dut.r_rf[2] !== 32'hFFFF_FFFD) begin errors++; $display("FAIL reg2: got %h want fffffffd", dut.r_rf[2]); end
        checks++; if (dut.r_rf[3] !== 32'd2) begin errors++; $display("FAIL add_reg3: got %h want 00000002", dut.r_rf[3]); end
        checks++; if (dut.r_rf[4] !== 32'd1) begin errors++; $display("FAIL slt_reg4: got %h want 00000001", dut.r_rf[4]); end
    endtask

    task automatic test_alu_ops();
        int c;
        clear_mem();
        mem[0] = 32'h2001_000C;   // addi $1,$0,12
        mem[1] = 32'h2002_000A;   // addi $2,$0,10
        mem[2] = 32'h0041_1822;   // sub  $3,$2,$1  -> -2
        mem[3] = 32'h0022_2024;   // and  $4,$1,$2  -> 8
        mem[4] = 32'h0022_2825;   // or   $5,$1,$2  -> 14
        mem[5] = 32'h2866_FFFF;   // slti $6,$3,-1  -> 1
        mem[6] = 32'h2827_0005;   // slti $7,$1,5   -> 0
        mem[7] = 32'h0800_0020;   // j 0x20 -> 0x80
        lat = 0;
        do_reset();
        for (int i = 0; i < 7; i++) begin
            wait_retire(20, c);
            checks++; if (c !== 4) begin errors++; $display("FAIL alu_latency_%0d: got %0d want 4", i, c); end
        end
        wait_retire(20, c);
        checks++; if (c !== 3) begin errors++; $display("FAIL j_latency: got %0d want 3", c); end
        step();
        checks++; if (pc !== 32'h80) begin errors++; $display("FAIL j_target: got %h want 00000080", pc); end
        checks++; if (dut.r_rf[3] !== 32'hFFFF_FFFE) begin errors++; $display("FAIL sub: got %h want fffffffe", dut.r_rf[3]); end
        checks++; if (dut.r_rf[4] !== 32'd8) begin errors++; $display("FAIL and: got %h want 00000008", dut.r_rf[4]); end
        checks++; if (dut.r_rf[5] !== 32'd14) begin errors++; $display("FAIL or: got %h want 0000000e", dut.r_rf[5]); end
        checks++; if (dut.r_rf[6] !== 32'd1) begin errors++; $display("FAIL slti_signed: got %h want 00000001", dut.r_rf[6]); end
        checks++; if (dut.r_rf[7] !== 32'd0) begin errors++; $display("FAIL slti_false: got %h want 00000000", dut.r_rf[7]); end
    endtask

    task automatic test_sw_lw();
        int c;
        int we_cyc;
        int f_cyc;
        int m_cyc;
        clear_mem();
        mem[0]  = 32'h0800_0010; // j 0x10 -> 0x40
        mem[16] = 32'h2003_0002; // addi $3,$0,2
        mem[17] = 32'hAC03_0008; // sw $3,8($0)
        mem[18] = 32'h8C05_0008; // lw $5,8($0)
        lat = 3;
        do_reset();
        wait_retire(40, c);
        checks++; if (c !== 6) begin errors++; $display("FAIL j_wait_latency: got %0d want 6", c); end
        wait_retire(40, c);
        checks++; if (c !== 7) begin errors++; $display("FAIL addi_wait_latency: got %0d want 7", c); end
        c = 0;
        we_cyc = 0;
        forever begin
            step();
            c++;
            if (mem_req === 1'b1 && mem_we === 1'b1) begin
                we_cyc++;
                checks++; if (mem_addr !== 32'h8 || mem_wdata !== 32'd2)
                    begin errors++; $display("FAIL sw_stable: addr=%h wdata=%h want 00000008 00000002", mem_addr, mem_wdata); end
            end
            if (retire === 1'b1 || c > 40) break;
        end
        checks++; if (c !== 10) begin errors++; $display("FAIL sw_latency: got %0d want 10", c); end
        checks++; if (we_cyc !== 4) begin errors++; $display("FAIL sw_req_cycles: got %0d want 4", we_cyc); end
        c = 0;
        f_cyc = 0;
        m_cyc = 0;
        forever begin
            step();
            c++;
            if (mem_req === 1'b1) begin
                if (mem_we === 1'b0 && mem_addr === 32'h48) f_cyc++;
                else if (mem_we === 1'b0 && mem_addr === 32'h8) m_cyc++;
                else begin
                    checks++; errors++;
                    $display("FAIL lw_req_stable: we=%b addr=%h want 0 and 00000048/00000008", mem_we, mem_addr);
                end
            end
            if (retire === 1'b1 || c > 40) break;
        end
        checks++; if (c !== 11) begin errors++; $display("FAIL lw_latency: got %0d want 11", c); end
        checks++; if (f_cyc !== 4 || m_cyc !== 4)
            begin errors++; $display("FAIL lw_req_cycles: fetch=%0d mem=%0d want 4 4", f_cyc, m_cyc); end
        checks++; if (mem[2] !== 32'd2) begin errors++; $display("FAIL sw_mem_word: got %h want 00000002", mem[2]); end
        step();
        checks++; if (dut.r_rf[5] !== 32'd2) begin errors++; $display("FAIL lw_reg5: got %h want 00000002", dut.r_rf[5]); end
    endtask

    task automatic test_branch();
        int c;
        clear_mem();
        mem[0] = 32'h2001_0005;   // addi $1,$0,5
        mem[1] = 32'h2002_FFFD;   // addi $2,$0,-3
        mem[2] = 32'h2006_0001;   // addi $6,$0,1
        mem[3] = 32'h2007_0001;   // addi $7,$0,1
        mem[4] = 32'h1021_FFFF;   // beq $1,$1,-1
        lat = 0;
        do_reset();
        for (int i = 0; i < 4; i++) wait_retire(20, c);
        for (int i = 0; i < 2; i++) begin
            wait_retire(20, c);
            checks++; if (c !== 3) begin errors++; $display("FAIL beq_taken_latency_%0d: got %0d want 3", i, c); end
        end
        mem[4] = 32'h1022_0005;   // beq $1,$2,5 (not taken)
        step();
        checks++; if (pc !== 32'h10) begin errors++; $display("FAIL beq_taken_pc: got %h want 00000010", pc); end
        wait_retire(20, c);
        checks++; if (c !== 2) begin errors++; $display("FAIL beq_not_taken_latency: got %0d want 2 (+1 fetch)", c); end
        step();
        checks++; if (pc !== 32'h14) begin errors++; $display("FAIL beq_not_taken_pc: got %h want 00000014", pc); end
    endtask

    task automatic test_jump_illegal();
        int c;
        int req_seen;
        clear_mem();
        mem[0]  = 32'h0C00_0040; // jal 0x40 -> 0x100
        mem[64] = 32'h03E0_0008; // jr $31
        mem[1]  = 32'h2000_0007; // addi $0,$0,7
        mem[2]  = 32'hFC00_0000; // opcode 0x3F
        lat = 0;
        do_reset();
        wait_retire(20, c);
        checks++; if (c !== 4) begin errors++; $display("FAIL jal_latency: got %0d want 4", c); end
        step();
        checks++; if (pc !== 32'h100) begin errors++; $display("FAIL jal_pc: got %h want 00000100", pc); end
        checks++; if (dut.r_rf[31] !== 32'd4) begin errors++; $display("FAIL jal_link: got %h want 00000004", dut.r_rf[31]); end
        wait_retire(20, c);
        checks++; if (c !== 2) begin errors++; $display("FAIL jr_latency: got %0d want 2 (+1 fetch)", c); end
        step();
        checks++; if (pc !== 32'h4) begin errors++; $display("FAIL jr_pc: got %h want 00000004", pc); end
        wait_retire(20, c);
        checks++; if (c !== 3) begin errors++; $display("FAIL addi_r0_latency: got %0d want 3 (+1 fetch)", c); end
        step();
        checks++; if (dut.r_rf[0] !== 32'd0) begin errors++; $display("FAIL r0_write: got %h want 00000000", dut.r_rf[0]); end
        checks++; if (pc !== 32'h8) begin errors++; $display("FAIL pc_before_illegal: got %h want 00000008", pc); end
        step();
        step();
        checks++; if (illegal !== 1'b1) begin errors++; $display("FAIL illegal_set: got %b want 1", illegal); end
        spur = 1'b1;
        req_seen = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (mem_req !== 1'b0 || retire !== 1'b0) req_seen++;
        end
        spur = 1'b0;
        checks++; if (req_seen !== 0) begin errors++; $display("FAIL halt_quiet: got %0d active cycles want 0", req_seen); end
        checks++; if (illegal !== 1'b1 || pc !== 32'h8)
            begin errors++; $display("FAIL halt_sticky: illegal=%b pc=%h want 1 00000008", illegal, pc); end
        rst = 1'b0;
        step();
        rst = 1'b1;
        checks++; if (illegal !== 1'b0 || pc !== 32'h0 || mem_req !== 1'b0)
            begin errors++; $display("FAIL halt_reset: illegal=%b pc=%h req=%b want 0 00000000 0", illegal, pc, mem_req); end
        checks++; if (dut.r_rf[31] !== 32'd0) begin errors++; $display("FAIL reset_regfile: got %h want 00000000", dut.r_rf[31]); end
    endtask

    task automatic test_reset_abort();
        int c;
        clear_mem();
        mem[0]  = 32'h2003_0002; // addi $3,$0,2
        mem[1]  = 32'hAC03_0040; // sw $3,0x40($0)
        mem[16] = 32'hDEAD_BEEF;
        lat = 0;
        hold_store = 1'b1;
        do_reset();
        wait_retire(20, c);
        c = 0;
        while (!(mem_req === 1'b1 && mem_we === 1'b1) && c < 20) begin
            step();
            c++;
        end
        step();
        step();
        checks++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h40)
            begin errors++; $display("FAIL sw_stall: req=%b we=%b addr=%h want 1 1 00000040", mem_req, mem_we, mem_addr); end
        rst = 1'b0;
        step();
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL abort_req: got %b want 0", mem_req); end
        checks++; if (mem[16] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL abort_mem: got %h want deadbeef", mem[16]); end
        checks++; if (dut.r_rf[3] !== 32'd0) begin errors++; $display("FAIL abort_regs: got %h want 00000000", dut.r_rf[3]); end
        hold_store = 1'b0;
        rst = 1'b1;
        step();
        checks++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h0)
            begin errors++; $display("FAIL refetch: req=%b we=%b addr=%h want 1 0 00000000", mem_req, mem_we, mem_addr); end
    endtask

    initial begin
        test_reset();
        test_alu_basic();
        test_alu_ops();
        test_sw_lw();
        test_branch();
        test_jump_illegal();
        test_reset_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
